// File: rtl/regfile_read_sequencer_if.sv
// regfile_read_sequencer_if: request/response, bitline and write-snoop bundle between ID stage, register bank and read sequencer
interface regfile_read_sequencer_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   raddr1;
  logic [ADDR_W-1:0]   raddr2;
  logic [NUM_REGS-1:0] ReadEnable1;
  logic [NUM_REGS-1:0] ReadEnable2;
  logic [WIDTH-1:0]    Bitline1;
  logic [WIDTH-1:0]    Bitline2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rdata1;
  logic [WIDTH-1:0]    rdata2;
  modport master (
    output req_valid, raddr1, raddr2, Bitline1, Bitline2, wr_en, wr_addr, wr_data, rsp_ready,
    input  req_ready, ReadEnable1, ReadEnable2, rsp_valid, rdata1, rdata2
  );
  modport slave (
    input  req_valid, raddr1, raddr2, Bitline1, Bitline2, wr_en, wr_addr, wr_data, rsp_ready,
    output req_ready, ReadEnable1, ReadEnable2, rsp_valid, rdata1, rdata2
  );
endinterface

// File: rtl/regfile_read_sequencer.sv
// regfile_read_sequencer: two-port bitline read controller (enable, settle, capture, respond); REGFILE_READ_BYPASS_EN adds write-to-read bypass on the capture edge
module regfile_read_sequencer #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input logic clk,
  input logic rst,
  regfile_read_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENABLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] a1, a2;
  logic              v1, v2, en_on;
  logic [WIDTH-1:0]  c1, c2;
  assign v1 = (a1 != '0) && (int'(a1) < NUM_REGS);
  assign v2 = (a2 != '0) && (int'(a2) < NUM_REGS);
  assign en_on = (state == ENABLE) || (state == CAPTURE);
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.ReadEnable1 = (en_on && v1) ? NUM_REGS'(1) << a1 : '0;
  assign bus.ReadEnable2 = (en_on && v2) ? NUM_REGS'(1) << a2 : '0;
`ifdef REGFILE_READ_BYPASS_EN
  assign c1 = (bus.wr_en && bus.wr_addr == a1) ? bus.wr_data : bus.Bitline1;
  assign c2 = (bus.wr_en && bus.wr_addr == a2) ? bus.wr_data : bus.Bitline2;
`else
  assign c1 = bus.Bitline1;
  assign c2 = bus.Bitline2;
`endif
  // next state: one settle cycle, one capture cycle, then hold the response until taken
  always_comb begin
    state_nx = state == IDLE    ? (bus.req_valid ? ENABLE : IDLE) :
               state == ENABLE  ? CAPTURE :
               state == CAPTURE ? RESP :
               (bus.rsp_ready ? IDLE : RESP);
  end
  // state, latched addresses and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a1         <= '0;
      a2         <= '0;
      bus.rdata1 <= '0;
      bus.rdata2 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req_valid) begin
        a1 <= bus.raddr1;
        a2 <= bus.raddr2;
      end
      if (state == CAPTURE) begin
        bus.rdata1 <= v1 ? c1 : '0;
        bus.rdata2 <= v2 ? c2 : '0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_read_sequencer.sv
// tb_regfile_read_sequencer: randomized read transactions against a snapshot model of the register bank
module tb_regfile_read_sequencer;
  localparam int W = 16;
  localparam int N = 16;
  localparam int A = 4;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] regs [N];
  logic [W-1:0] mdl [N];
  logic [W-1:0] bl1, bl2;
  time acc [$];
  always #5 clk = ~clk;
  regfile_read_sequencer_if #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(A)) bus ();
  regfile_read_sequencer #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(A)) dut (.clk(clk), .rst(rst), .bus(bus));
  always @(posedge clk) if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
  always_comb begin
    bl1 = 16'hDEAD;
    bl2 = 16'hA5A5;
    for (int i = 0; i < N; i++) begin
      if (bus.ReadEnable1[i]) bl1 = regs[i];
      if (bus.ReadEnable2[i]) bl2 = regs[i];
    end
  end
  assign bus.Bitline1 = bl1;
  assign bus.Bitline2 = bl2;
  always @(posedge clk) if (!rst && bus.req_valid && bus.req_ready) acc.push_back($time);
  always @(negedge clk) if (!rst) chk("onehot", {30'd0, $onehot0(bus.ReadEnable1), $onehot0(bus.ReadEnable2)}, 32'd3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int a);
    logic [N-1:0] r = '0;
    if (a > 0 && a < N) r[a] = 1'b1;
    return r;
  endfunction

  task automatic wr(input int a, input logic [W-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = A'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    mdl[a] = d;
  endtask

  // ph: 0 no write, 1 write in ENABLE, 2 write in CAPTURE, 3 write in RESP
  task automatic rd(input int a1, input int a2, input int ph, input int wa, input logic [W-1:0] wd, input int bp);
    logic [W-1:0] snap [N];
    logic [W-1:0] e1, e2;
    snap = mdl;
    if (ph == 1) snap[wa] = wd;
    e1 = (a1 > 0 && a1 < N) ? snap[a1] : '0;
    e2 = (a2 > 0 && a2 < N) ? snap[a2] : '0;
`ifdef REGFILE_READ_BYPASS_EN
    if (ph == 2 && wa == a1 && a1 > 0 && a1 < N) e1 = wd;
    if (ph == 2 && wa == a2 && a2 > 0 && a2 < N) e2 = wd;
`endif
    bus.req_valid = 1'b1;
    bus.raddr1 = A'(a1);
    bus.raddr2 = A'(a2);
    bus.wr_addr = A'(wa);
    bus.wr_data = wd;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wr_en = ph == 1;
    chk("enable_en1", 32'(bus.ReadEnable1), 32'(oh(a1)));
    chk("enable_en2", 32'(bus.ReadEnable2), 32'(oh(a2)));
    chk("enable_req_ready", 32'(bus.req_ready), 32'd0);
    chk("enable_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.wr_en = ph == 2;
    chk("capture_en1", 32'(bus.ReadEnable1), 32'(oh(a1)));
    chk("capture_en2", 32'(bus.ReadEnable2), 32'(oh(a2)));
    chk("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.wr_en = ph == 3;
    bus.rsp_ready = bp == 0;
    chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_rdata1", 32'(bus.rdata1), 32'(e1));
    chk("resp_rdata2", 32'(bus.rdata2), 32'(e2));
    chk("resp_en", 32'({bus.ReadEnable1, bus.ReadEnable2}), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata1", 32'(bus.rdata1), 32'(e1));
      chk("hold_rdata2", 32'(bus.rdata2), 32'(e2));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_req_ready", 32'(bus.req_ready), 32'd1);
    if (ph != 0) mdl[wa] = wd;
  endtask

  initial begin
    int a1, a2;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_en", 32'({bus.ReadEnable1, bus.ReadEnable2}), 32'd0);
    chk("rst_rdata", 32'({bus.rdata1, bus.rdata2}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) wr(i, W'($urandom));
    wr(3, 16'hBEEF);
    wr(5, 16'h1234);
    rd(3, 5, 0, 0, '0, 0);
    wr(7, 16'h00FF);
    rd(0, 7, 0, 0, '0, 5);
    wr(4, 16'h1111);
    rd(4, 4, 2, 4, 16'h2222, 0);
    bus.req_valid = 1'b1;
    bus.raddr1 = 4'd6;
    bus.raddr2 = 4'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_en", 32'({bus.ReadEnable1, bus.ReadEnable2}), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rdata", 32'({bus.rdata1, bus.rdata2}), 32'd0);
    @(negedge clk);
    chk("midrst_still_idle", 32'({bus.req_ready, bus.rsp_valid}), 32'd2);
    rd(6, 9, 0, 0, '0, 0);
    acc.delete();
    rd(1, 2, 0, 0, '0, 0);
    rd(2, 1, 0, 0, '0, 0);
    chk("b2b_accepts", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd40);
    repeat (40) begin
      a1 = $urandom_range(0, N - 1);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : int'($urandom_range(0, N - 1));
      rd(a1, a2, $urandom_range(0, 3), $urandom_range(0, 1) ? a1 : int'($urandom_range(0, N - 1)), W'($urandom), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
